// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous data RAM (CPU = port 0, debug = port 1).
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise the CPU always wins a tie.
module mem_arbiter #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ack,
    output logic [DW-1:0] dbg_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          owner_q, owner_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
    logic          grant_dbg;

`ifdef MEM_ARB_RR_EN
    logic last_grant_q, last_grant_d;

    // On a tie the port that did not win the previous grant goes next.
    assign grant_dbg = dbg_req & (~cpu_req | ~last_grant_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == IDLE && (cpu_req || dbg_req)) begin
            last_grant_d = grant_dbg;
        end
    end
`else
    assign grant_dbg = dbg_req & ~cpu_req;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        owner_d     = owner_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        case (state_q)
            IDLE: begin
                if (cpu_req || dbg_req) begin
                    owner_d = grant_dbg;
                    addr_d  = grant_dbg ? dbg_addr  : cpu_addr;
                    we_d    = grant_dbg ? dbg_we    : cpu_we;
                    wdata_d = grant_dbg ? dbg_wdata : cpu_wdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = RESP;
            end
            RESP: begin
                // RAM output is valid this cycle; only the owner's read register moves.
                if (!we_q) begin
                    if (owner_q) begin
                        dbg_rdata_d = mem_rdata;
                    end else begin
                        cpu_rdata_d = mem_rdata;
                    end
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            owner_q     <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            owner_q     <= owner_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    // Outputs decode the state register, so an asynchronous reset clears them at once.
    assign mem_en    = (state_q == ISSUE);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != IDLE);
    assign cpu_ack   = (state_q == RESP) & ~owner_q;
    assign dbg_ack   = (state_q == RESP) &  owner_q;
    // The read value is forwarded during the ack cycle and held by the register afterwards.
    assign cpu_rdata = cpu_rdata_d;
    assign dbg_rdata = dbg_rdata_d;
    assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table of single arbitration rounds plus
// hand-written sequences for reset mid-access, abandoned requests and round-robin ties.
module tb_mem_arbiter;

    localparam int AW = 10;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, dbg_req, dbg_we;
    logic [AW-1:0] cpu_addr, dbg_addr;
    logic [DW-1:0] cpu_wdata, dbg_wdata;
    logic          cpu_ack, cpu_stall, dbg_ack;
    logic [DW-1:0] cpu_rdata, dbg_rdata;
    logic          mem_en, mem_we, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    logic [DW-1:0] ram [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] m_cpu_rd = '0;
    logic [DW-1:0] m_dbg_rd = '0;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM: read data appears the cycle after mem_en.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    typedef struct {
        logic          creq;
        logic          cwe;
        logic [AW-1:0] caddr;
        logic [DW-1:0] cwd;
        logic          dreq;
        logic          dwe;
        logic [AW-1:0] daddr;
        logic [DW-1:0] dwd;
        logic          tie;
        logic          owner;
        logic [DW-1:0] rd;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // One arbitration round, entered and left with the arbiter in IDLE.
    task automatic run_round(input vec_t v, input int idx);
        int            stall_cnt;
        logic [AW-1:0] ea;
        logic          ewe;
        logic [DW-1:0] ewd;
        stall_cnt = 0;
        ea  = v.owner ? v.daddr : v.caddr;
        ewe = v.owner ? v.dwe   : v.cwe;
        ewd = v.owner ? v.dwd   : v.cwd;
        cpu_req = v.creq; cpu_we = v.cwe; cpu_addr = v.caddr; cpu_wdata = v.cwd;
        dbg_req = v.dreq; dbg_we = v.dwe; dbg_addr = v.daddr; dbg_wdata = v.dwd;
        #1;
        check("idle_busy", busy, 0);
        check("idle_mem_en", mem_en, 0);
        stall_cnt += int'(cpu_stall);
        step();
        check("issue_mem_en", mem_en, 1);
        check("issue_mem_addr", mem_addr, ea);
        check("issue_mem_we", mem_we, ewe);
        if (ewe) check("issue_mem_wdata", mem_wdata, ewd);
        check("issue_no_ack", {cpu_ack, dbg_ack}, 0);
        stall_cnt += int'(cpu_stall);
        step();
        check("resp_mem_en", mem_en, 0);
        check("resp_cpu_ack", cpu_ack, !v.owner);
        check("resp_dbg_ack", dbg_ack, v.owner);
        if (!ewe) begin
            if (v.owner) m_dbg_rd = v.rd;
            else         m_cpu_rd = v.rd;
        end
        check("resp_cpu_rdata", cpu_rdata, m_cpu_rd);
        check("resp_dbg_rdata", dbg_rdata, m_dbg_rd);
        stall_cnt += int'(cpu_stall);
        if (!v.owner) check("cpu_stall_cycles", stall_cnt, 2);
        if (v.owner) dbg_req = 1'b0;
        else         cpu_req = 1'b0;
        step();
        check("bubble_busy", busy, 0);
        check("bubble_acks", {cpu_ack, dbg_ack}, 0);
        check("hold_cpu_rdata", cpu_rdata, m_cpu_rd);
        check("hold_dbg_rdata", dbg_rdata, m_dbg_rd);
        $display("txn %0d: owner=%s addr=%03h we=%0d wdata=%04h cpu_rdata=%04h dbg_rdata=%04h",
                 idx, v.owner ? "dbg" : "cpu", ea, ewe, ewd, cpu_rdata, dbg_rdata);
    endtask

    initial begin
        int mem_en_cnt;
        int ack_cnt;
        for (int i = 0; i < (1 << AW); i++) ram[i] = '0;

        //            creq cwe  caddr   cwd       dreq dwe  daddr   dwd       tie  own  rd
        vecs[0]  = '{1'b1, 1'b1, 10'h005, 16'h1234, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 16'h0000};
        vecs[1]  = '{1'b1, 1'b0, 10'h005, 16'h0000, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 16'h1234};
        vecs[2]  = '{1'b0, 1'b0, 10'h000, 16'h0000, 1'b1, 1'b1, 10'h3FF, 16'h00AA, 1'b0, 1'b1, 16'h0000};
        vecs[3]  = '{1'b1, 1'b0, 10'h3FF, 16'h0000, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 16'h00AA};
        vecs[4]  = '{1'b1, 1'b1, 10'h010, 16'h1111, 1'b1, 1'b0, 10'h3FF, 16'h0000, 1'b1, 1'b0, 16'h0000};
        vecs[5]  = '{1'b1, 1'b0, 10'h010, 16'h0000, 1'b1, 1'b0, 10'h3FF, 16'h0000, 1'b1, 1'b0, 16'h1111};
        vecs[6]  = '{1'b1, 1'b1, 10'h011, 16'h2222, 1'b1, 1'b0, 10'h3FF, 16'h0000, 1'b1, 1'b0, 16'h0000};
        vecs[7]  = '{1'b0, 1'b0, 10'h000, 16'h0000, 1'b1, 1'b0, 10'h3FF, 16'h0000, 1'b0, 1'b1, 16'h00AA};
        vecs[8]  = '{1'b0, 1'b0, 10'h000, 16'h0000, 1'b1, 1'b0, 10'h005, 16'h0000, 1'b0, 1'b1, 16'h1234};
        vecs[9]  = '{1'b1, 1'b1, 10'h000, 16'hFFFF, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 16'h0000};
        vecs[10] = '{1'b1, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 16'hFFFF};
        vecs[11] = '{1'b0, 1'b0, 10'h000, 16'h0000, 1'b1, 1'b0, 10'h011, 16'h0000, 1'b1, 1'b1, 16'h2222};

        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        step();
        step();
        check("rst_mem_en", mem_en, 0);
        check("rst_busy", busy, 0);
        check("rst_acks", {cpu_ack, dbg_ack}, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_dbg_rdata", dbg_rdata, 0);
        check("rst_mem_fields", {mem_we, mem_addr, mem_wdata}, 0);
        check("rst_stall", cpu_stall, 0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
`ifdef MEM_ARB_RR_EN
            if (vecs[i].tie) continue;
`endif
            run_round(vecs[i], i);
        end

`ifdef MEM_ARB_RR_EN
        // Both ports held high from reset: grants alternate starting with the CPU.
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_cpu_rd = '0; m_dbg_rd = '0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 10'h030; cpu_wdata = 16'hC0C0;
        dbg_req = 1; dbg_we = 1; dbg_addr = 10'h031; dbg_wdata = 16'hD0D0;
        #1;
        for (int c = 1; c <= 12; c++) begin
            step();
            check("rr_cpu_ack", cpu_ack, (c == 2 || c == 8));
            check("rr_dbg_ack", dbg_ack, (c == 5 || c == 11));
        end
        cpu_req = 0; dbg_req = 0;
        $display("txn rr: four alternating grants cpu,dbg,cpu,dbg");
        step();
        step();
`endif

        // Reset cuts a CPU write during its ISSUE cycle.
        cpu_req = 1; cpu_we = 1; cpu_addr = 10'h020; cpu_wdata = 16'hBEEF;
        dbg_req = 0;
        step();
        check("cut_issue_mem_en", mem_en, 1);
        reset = 1'b1;
        #1;
        check("cut_mem_en", mem_en, 0);
        check("cut_busy", busy, 0);
        check("cut_acks", {cpu_ack, dbg_ack}, 0);
        check("cut_rdata", {cpu_rdata, dbg_rdata}, 0);
        check("cut_mem_fields", {mem_we, mem_addr, mem_wdata}, 0);
        cpu_req = 0;
        step();
        check("cut_no_ack", {cpu_ack, dbg_ack}, 0);
        reset = 1'b0;
        m_cpu_rd = '0; m_dbg_rd = '0;
        $display("txn reset: write of BEEF cut in ISSUE");
        run_round(vecs[1], 12);

        // Abandoned request: req drops after the grant and the inputs change.
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h005; cpu_wdata = '0;
        #1;
        check("ab_stall", cpu_stall, 1);
        step();
        check("ab_mem_en", mem_en, 1);
        cpu_req = 0; cpu_addr = 10'h3FF; cpu_we = 1;
        #1;
        check("ab_mem_addr", mem_addr, 10'h005);
        check("ab_mem_we", mem_we, 0);
        check("ab_stall_low", cpu_stall, 0);
        step();
        check("ab_cpu_ack", cpu_ack, 1);
        check("ab_cpu_rdata", cpu_rdata, 16'h1234);
        mem_en_cnt = 0;
        ack_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            mem_en_cnt += int'(mem_en);
            ack_cnt += int'(cpu_ack) + int'(dbg_ack);
        end
        check("ab_no_reissue", mem_en_cnt, 0);
        check("ab_no_second_ack", ack_cnt, 0);
        check("ab_rdata_held", cpu_rdata, 16'h1234);
        $display("txn abandoned: cpu read 005 completed once, rdata=%04h", cpu_rdata);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
